// File: rtl/pipe_ctrl_pkg.sv
// Shared types and decode helpers for the pipeline control unit.
// Address fields are sized for the widest supported core (REG_AW <= 8, IR_W <= 32).
package pipe_ctrl_pkg;

    localparam int IR_W_MAX   = 32;
    localparam int REG_AW_MAX = 8;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ALU1  = 4'h1,
        OP_ALU2  = 4'h2,
        OP_ALU3  = 4'h3,
        OP_ALU4  = 4'h4,
        OP_ALU5  = 4'h5,
        OP_ALU6  = 4'h6,
        OP_ALU7  = 4'h7,
        OP_LOAD  = 4'h8,
        OP_STORE = 4'h9
    } opcode_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef logic [REG_AW_MAX-1:0] reg_addr_t;

    // Unused source fields are stored as r0 so downstream compares need no use flags.
    typedef struct packed {
        opcode_e   op;
        reg_addr_t rd;
        reg_addr_t rs1;
        reg_addr_t rs2;
        logic      writes;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_NOP = '{op: OP_NOP, rd: '0, rs1: '0, rs2: '0, writes: 1'b0};

    function automatic reg_addr_t field(input logic [IR_W_MAX-1:0] ir, input int lsb, input int reg_aw);
        reg_addr_t mask;
        mask = reg_addr_t'((1 << reg_aw) - 1);
        return reg_addr_t'(ir >> lsb) & mask;
    endfunction

    function automatic logic is_alu(input opcode_e op);
        return (op != OP_NOP) && !op[3];
    endfunction

    function automatic stage_ctrl_t decode(input logic [IR_W_MAX-1:0] ir, input int ir_w, input int reg_aw);
        stage_ctrl_t s;
        logic [3:0]  raw;
        logic        rd_use, rs1_use, rs2_use;
        raw     = 4'(ir >> (ir_w - 4));
        rd_use  = (raw >= 4'h1) && (raw <= 4'h8);
        rs1_use = (raw >= 4'h1) && (raw <= 4'h9);
        rs2_use = ((raw >= 4'h1) && (raw <= 4'h7)) || (raw == 4'h9);
        // NOTE: start from a full default so every field is assigned on every path.
        s = STAGE_NOP;
        if (raw <= 4'h9) s.op = opcode_e'(raw);
        if (rd_use)  s.rd  = field(ir, ir_w - 4 - reg_aw, reg_aw);
        if (rs1_use) s.rs1 = field(ir, ir_w - 4 - 2 * reg_aw, reg_aw);
        if (rs2_use) s.rs2 = field(ir, ir_w - 4 - 3 * reg_aw, reg_aw);
        s.writes = (s.rd != '0);
        return s;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the fetch/decode front end and the pipeline control unit.
interface pipe_ctrl_if #(
    parameter int IR_W   = 16,
    parameter int REG_AW = 4
);
    logic [IR_W-1:0]   i_ir_id;
    logic              i_hold;
    logic              o_stall;
    logic [2:0]        o_alu_sel;
    logic              o_mem_rd_en;
    logic              o_mem_wr_en;
    logic [REG_AW-1:0] o_addr_rd_r;
    logic              o_registers_rd_en;
    logic [1:0]        o_fwd_a;
    logic [1:0]        o_fwd_b;

    modport master (
        output i_ir_id, i_hold,
        input  o_stall, o_alu_sel, o_mem_rd_en, o_mem_wr_en,
               o_addr_rd_r, o_registers_rd_en, o_fwd_a, o_fwd_b
    );

    modport slave (
        input  i_ir_id, i_hold,
        output o_stall, o_alu_sel, o_mem_rd_en, o_mem_wr_en,
               o_addr_rd_r, o_registers_rd_en, o_fwd_a, o_fwd_b
    );
endinterface

// File: rtl/pipe_ctrl_hazard.sv
// Combinational RAW-hazard stall and operand-forwarding select logic.
// PIPE_CTRL_FWD_EN builds the forwarding compares and restricts stalls to load-use.
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
(
    input  stage_ctrl_t id,
    input  stage_ctrl_t ex,
    input  stage_ctrl_t mem,
    input  stage_ctrl_t wb,
    output logic        stall,
    output fwd_sel_e    fwd_a,
    output fwd_sel_e    fwd_b
);

    function automatic logic hit(input reg_addr_t src, input stage_ctrl_t st);
        return (src != '0) && st.writes && (st.rd == src);
    endfunction

    // Not every field feeds logic in every build; fold them into one sink.
    logic unused_bits;
    assign unused_bits = ^{id, ex, mem, wb};

`ifdef PIPE_CTRL_FWD_EN
    function automatic fwd_sel_e pick(input reg_addr_t src, input stage_ctrl_t m, input stage_ctrl_t w);
        if (hit(src, m)) return FWD_EXMEM;
        if (hit(src, w)) return FWD_MEMWB;
        return FWD_RF;
    endfunction

    // A load's data only exists after MEM, so the consumer must wait one slot.
    assign stall = (ex.op == OP_LOAD) && (hit(id.rs1, ex) || hit(id.rs2, ex));
    assign fwd_a = pick(ex.rs1, mem, wb);
    assign fwd_b = pick(ex.rs2, mem, wb);
`else
    // The register file has no write-through, so a writer still in WB blocks the read.
    assign stall = hit(id.rs1, ex) || hit(id.rs1, mem) || hit(id.rs1, wb) ||
                   hit(id.rs2, ex) || hit(id.rs2, mem) || hit(id.rs2, wb);
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline control: decodes ID and carries control through EX, MEM and WB.
// Forwarding is compiled in with PIPE_CTRL_FWD_EN. Requires IR_W >= 4 + 3*REG_AW.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int IR_W   = 16,
    parameter int REG_AW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  bus
);

    stage_ctrl_t id_dec;
    stage_ctrl_t ex_q, mem_q, wb_q;
    logic        stall;
    fwd_sel_e    fwd_a, fwd_b;

    assign id_dec = decode(IR_W_MAX'(bus.i_ir_id), IR_W, REG_AW);

    pipe_ctrl_hazard u_hazard (
        .id    (id_dec),
        .ex    (ex_q),
        .mem   (mem_q),
        .wb    (wb_q),
        .stall (stall),
        .fwd_a (fwd_a),
        .fwd_b (fwd_b)
    );

    // NOTE: non-blocking assignments let MEM capture the old EX value on the same edge EX reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= STAGE_NOP;
            mem_q <= STAGE_NOP;
            wb_q  <= STAGE_NOP;
        end else if (!bus.i_hold) begin
            ex_q  <= stall ? STAGE_NOP : id_dec;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign bus.o_stall           = stall;
    assign bus.o_alu_sel         = is_alu(ex_q.op) ? ex_q.op[2:0] : 3'd0;
    assign bus.o_mem_rd_en       = (mem_q.op == OP_LOAD);
    assign bus.o_mem_wr_en       = (mem_q.op == OP_STORE);
    assign bus.o_addr_rd_r       = wb_q.rd[REG_AW-1:0];
    assign bus.o_registers_rd_en = wb_q.writes;
    assign bus.o_fwd_a           = fwd_a;
    assign bus.o_fwd_b           = fwd_b;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic against a
// stage-occupancy reference model. Build with +define+PIPE_CTRL_FWD_EN to cover forwarding.
module tb_pipe_ctrl;

    localparam int IR_W   = 16;
    localparam int REG_AW = 4;

`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    pipe_ctrl_if #(.IR_W(IR_W), .REG_AW(REG_AW)) bus ();

    pipe_ctrl #(.IR_W(IR_W), .REG_AW(REG_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: the raw instruction word occupying each stage (0 = empty).
    int ex_ir = 0, mem_ir = 0, wb_ir = 0;

    function automatic int fld(input int ir, input int lsb);
        return (ir >> lsb) & ((1 << REG_AW) - 1);
    endfunction

    function automatic int opc(input int ir);
        int r;
        r = (ir >> (IR_W - 4)) & 15;
        return (r <= 9) ? r : 0;
    endfunction

    function automatic int dest(input int ir);
        int o;
        o = opc(ir);
        return (o >= 1 && o <= 8) ? fld(ir, IR_W - 4 - REG_AW) : 0;
    endfunction

    function automatic int src1(input int ir);
        int o;
        o = opc(ir);
        return (o >= 1 && o <= 9) ? fld(ir, IR_W - 4 - 2 * REG_AW) : 0;
    endfunction

    function automatic int src2(input int ir);
        int o;
        o = opc(ir);
        return ((o >= 1 && o <= 7) || o == 9) ? fld(ir, IR_W - 4 - 3 * REG_AW) : 0;
    endfunction

    function automatic bit m_stall(input int id);
        int s [2];
        s[0] = src1(id);
        s[1] = src2(id);
        foreach (s[i]) begin
            if (s[i] != 0) begin
                if (FWD) begin
                    if (opc(ex_ir) == 8 && dest(ex_ir) == s[i]) return 1'b1;
                end else begin
                    if (dest(ex_ir) == s[i] || dest(mem_ir) == s[i] || dest(wb_ir) == s[i]) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic int m_fwd(input int src);
        if (!FWD || src == 0) return 0;
        if (dest(mem_ir) == src) return 1;
        if (dest(wb_ir) == src) return 2;
        return 0;
    endfunction

    // Drive one cycle (entered and left at negedge+1), checking every output beforehand.
    task automatic cycle(input int ir, input bit h, output bit stalled);
        int o_ex;
        bus.i_ir_id = IR_W'(ir);
        bus.i_hold  = h;
        #1;
        stalled = m_stall(ir);
        o_ex    = opc(ex_ir);
        check("stall",     int'(bus.o_stall),           int'(stalled));
        check("alu_sel",   int'(bus.o_alu_sel),         (o_ex >= 1 && o_ex <= 7) ? o_ex : 0);
        check("mem_rd_en", int'(bus.o_mem_rd_en),       int'(opc(mem_ir) == 8));
        check("mem_wr_en", int'(bus.o_mem_wr_en),       int'(opc(mem_ir) == 9));
        check("addr_rd_r", int'(bus.o_addr_rd_r),       dest(wb_ir));
        check("rd_en",     int'(bus.o_registers_rd_en), int'(dest(wb_ir) != 0));
        check("fwd_a",     int'(bus.o_fwd_a),           m_fwd(src1(ex_ir)));
        check("fwd_b",     int'(bus.o_fwd_b),           m_fwd(src2(ex_ir)));
        @(posedge clk);
        if (!h) begin
            wb_ir  = mem_ir;
            mem_ir = ex_ir;
            ex_ir  = stalled ? 0 : ir;
        end
        @(negedge clk);
        #1;
    endtask

    // Present one instruction in ID until it is accepted; report how many cycles it stalled.
    task automatic issue(input int ir, output int n_stall);
        bit s;
        n_stall = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(ir, 1'b0, s);
            if (!s) return;
            n_stall++;
        end
        check("issue_timeout", n_stall, 0);
    endtask

    task automatic nops(input int k);
        bit s;
        for (int i = 0; i < k; i++) cycle(0, 1'b0, s);
    endtask

    task automatic pair(input string tag, input int gap, input int exp_stall, input int exp_fwd);
        int n;
        nops(3);
        issue(16'h1123, n);
        nops(gap);
        issue(16'h2410, n);
        check({tag, "_stall_cycles"}, n, exp_stall);
        check({tag, "_alu_sel"}, int'(bus.o_alu_sel), 2);
        check({tag, "_fwd_a"}, int'(bus.o_fwd_a), exp_fwd);
    endtask

    function automatic int rand_ir();
        int op, rd, a, b;
        op = $urandom_range(0, 15);
        rd = $urandom_range(0, 3);
        a  = $urandom_range(0, 3);
        b  = $urandom_range(0, 3);
        return (op << (IR_W - 4)) | (rd << (IR_W - 4 - REG_AW)) |
               (a << (IR_W - 4 - 2 * REG_AW)) | (b << (IR_W - 4 - 3 * REG_AW));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit s, h, accepted;
        int cur;

        rst_n       = 1'b1;
        bus.i_ir_id = 16'h1123;
        bus.i_hold  = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall",     int'(bus.o_stall),           0);
        check("rst_alu_sel",   int'(bus.o_alu_sel),         0);
        check("rst_mem_rd_en", int'(bus.o_mem_rd_en),       0);
        check("rst_mem_wr_en", int'(bus.o_mem_wr_en),       0);
        check("rst_addr_rd_r", int'(bus.o_addr_rd_r),       0);
        check("rst_rd_en",     int'(bus.o_registers_rd_en), 0);
        check("rst_fwd_a",     int'(bus.o_fwd_a),           0);
        check("rst_fwd_b",     int'(bus.o_fwd_b),           0);
        rst_n = 1'b1;

        cycle(16'h1123, 1'b0, s);
        check("first_alu_sel", int'(bus.o_alu_sel), 1);
        nops(2);
        check("first_addr_rd_r", int'(bus.o_addr_rd_r), 1);
        check("first_rd_en", int'(bus.o_registers_rd_en), 1);

        pair("b2b",  0, FWD ? 0 : 3, FWD ? 1 : 0);
        pair("gap1", 1, FWD ? 0 : 2, FWD ? 2 : 0);
        pair("gap2", 2, FWD ? 0 : 1, 0);

        nops(3);
        issue(16'h8500, n);
        issue(16'h3650, n);
        check("load_use_stall_cycles", n, FWD ? 1 : 3);
        check("load_use_fwd_a", int'(bus.o_fwd_a), FWD ? 2 : 0);
        check("load_use_mem_rd_en", int'(bus.o_mem_rd_en), 0);

        nops(3);
        issue(16'h1100, n);
        issue(16'h2200, n);
        check("r0_stall_cycles", n, 0);
        check("r0_fwd_a", int'(bus.o_fwd_a), 0);
        check("r0_fwd_b", int'(bus.o_fwd_b), 0);
        issue(16'h9012, n);
        check("store_stall_cycles", n, FWD ? 0 : 3);
        check("store_fwd_a", int'(bus.o_fwd_a), FWD ? 2 : 0);
        check("store_fwd_b", int'(bus.o_fwd_b), FWD ? 1 : 0);
        nops(1);
        check("store_mem_wr_en", int'(bus.o_mem_wr_en), 1);
        nops(1);
        check("store_rd_en", int'(bus.o_registers_rd_en), 0);

        nops(3);
        issue(16'h1123, n);
        issue(16'h5700, n);
        for (int i = 0; i < 4; i++) cycle(16'h2410, 1'b1, s);
        check("hold_alu_sel", int'(bus.o_alu_sel), 5);
        issue(16'h2410, n);
        check("hold_resume_stall_cycles", n, FWD ? 0 : 2);
        check("hold_resume_fwd_a", int'(bus.o_fwd_a), FWD ? 2 : 0);

        nops(3);
        issue(16'h8500, n);
        bus.i_ir_id = 16'h3650;
        #1;
        check("pre_reset_stall", int'(bus.o_stall), 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_stall", int'(bus.o_stall), 0);
        check("mid_reset_alu_sel", int'(bus.o_alu_sel), 0);
        ex_ir  = 0;
        mem_ir = 0;
        wb_ir  = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        cur = rand_ir();
        for (int i = 0; i < 400; i++) begin
            h = ($urandom_range(0, 9) == 0);
            cycle(cur, h, s);
            accepted = !s && !h;
            if (accepted) cur = rand_ir();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
